// File: rtl/l2_request_issue_pkg.sv
// Shared L2 request definitions: op encodings, line geometry and the
// per-request record carried from a unit slot to the L2 request port.
package l2_request_issue_pkg;

  localparam int unsigned L2_ADDR_W     = 26;
  localparam int unsigned L2_LINE_BYTES = 64;
  localparam int unsigned L2_LINE_BITS  = L2_LINE_BYTES * 8;
  localparam int unsigned L2_STRAND_W   = 2;
  localparam int unsigned L2_WAY_W      = 2;
  localparam int unsigned L2_OP_W       = 3;
  localparam int unsigned L2_UNIT_W     = 2;
  localparam int unsigned L2_MAX_UNITS  = 4;

  typedef enum logic [L2_OP_W-1:0] {
    L2REQ_LOAD       = 3'd0,
    L2REQ_STORE      = 3'd1,
    L2REQ_FLUSH      = 3'd2,
    L2REQ_INVALIDATE = 3'd3,
    L2REQ_LOAD_SYNC  = 3'd4,
    L2REQ_STORE_SYNC = 3'd5
  } l2req_op_e;

  typedef struct packed {
    logic [L2_STRAND_W-1:0]   strand;
    logic [L2_OP_W-1:0]       op;
    logic [L2_WAY_W-1:0]      way;
    logic [L2_ADDR_W-1:0]     address;
    logic [L2_LINE_BITS-1:0]  data;
    logic [L2_LINE_BYTES-1:0] mask;
  } l2req_t;

  // Round-robin successor of a unit index, wrapping at num_units.
  function automatic logic [L2_UNIT_W-1:0] rr_next(input logic [L2_UNIT_W-1:0] idx,
                                                   input int unsigned           num_units);
    return (32'(idx) == num_units - 32'd1) ? '0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/l2_request_issue_if.sv
// Unit-side request bundle plus the L2 request port.
// master: the issue block (accepts unit requests, drives l2req_*).
// slave : its peers (cache units and the L2 arbitration stage).
interface l2_request_issue_if
  import l2_request_issue_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4
);

  logic [NUM_UNITS-1:0]               req_valid;
  logic [NUM_UNITS-1:0]               req_ready;
  logic [L2_STRAND_W*NUM_UNITS-1:0]   req_strand;
  logic [L2_OP_W*NUM_UNITS-1:0]       req_op;
  logic [L2_WAY_W*NUM_UNITS-1:0]      req_way;
  logic [L2_ADDR_W*NUM_UNITS-1:0]     req_address;
  logic [L2_LINE_BITS*NUM_UNITS-1:0]  req_data;
  logic [L2_LINE_BYTES*NUM_UNITS-1:0] req_mask;

  logic                               l2req_valid;
  logic                               l2req_ready;
  logic [L2_UNIT_W-1:0]               l2req_unit;
  logic [L2_STRAND_W-1:0]             l2req_strand;
  logic [L2_OP_W-1:0]                 l2req_op;
  logic [L2_WAY_W-1:0]                l2req_way;
  logic [L2_ADDR_W-1:0]               l2req_address;
  logic [L2_LINE_BITS-1:0]            l2req_data;
  logic [L2_LINE_BYTES-1:0]           l2req_mask;

  modport master (
    input  req_valid, req_strand, req_op, req_way, req_address, req_data, req_mask,
    output req_ready,
    input  l2req_ready,
    output l2req_valid, l2req_unit, l2req_strand, l2req_op, l2req_way,
           l2req_address, l2req_data, l2req_mask
  );

  modport slave (
    output req_valid, req_strand, req_op, req_way, req_address, req_data, req_mask,
    input  req_ready,
    output l2req_ready,
    input  l2req_valid, l2req_unit, l2req_strand, l2req_op, l2req_way,
           l2req_address, l2req_data, l2req_mask
  );

endinterface

// File: rtl/l2_request_issue_rr_arbiter.sv
// Round-robin pick: first requesting unit at or after ptr_i, wrapping.
module l2_request_issue_rr_arbiter
  import l2_request_issue_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4
) (
  input  logic [NUM_UNITS-1:0] req_i,
  input  logic [L2_UNIT_W-1:0] ptr_i,
  output logic [NUM_UNITS-1:0] grant_o,
  output logic [L2_UNIT_W-1:0] idx_o,
  output logic                 any_o
);

  localparam int unsigned SUM_W = L2_UNIT_W + 1;

  logic [SUM_W-1:0]     cand_sum;
  logic [L2_UNIT_W-1:0] cand;

  // Scan units starting at the pointer; first hit wins
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      cand_sum = {1'b0, ptr_i} + SUM_W'(k);
      if (cand_sum >= SUM_W'(NUM_UNITS)) begin
        cand_sum = cand_sum - SUM_W'(NUM_UNITS);
      end
      cand = cand_sum[L2_UNIT_W-1:0];
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/l2_request_issue.sv
// L2 request issue: one buffered request per L1-side unit, round-robin
// selection into a single valid/ready output register toward L2.
// Optional: define L2REQ_STALL_COUNT_EN to add perf_l2req_stall_count,
// counting cycles where the output is valid but not accepted.
module l2_request_issue
  import l2_request_issue_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  l2_request_issue_if.master        bus
`ifdef L2REQ_STALL_COUNT_EN
  ,
  output logic [31:0]               perf_l2req_stall_count
`endif
);

  l2req_t               slot_q [NUM_UNITS];
  l2req_t               slot_d [NUM_UNITS];
  logic [NUM_UNITS-1:0] pending_q, pending_d;
  logic [NUM_UNITS-1:0] capture;

  l2req_t               out_q, out_d;
  logic                 valid_q, valid_d;
  logic [L2_UNIT_W-1:0] unit_q, unit_d;
  logic [L2_UNIT_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_UNITS-1:0] grant;
  logic [L2_UNIT_W-1:0] grant_idx;
  logic                 grant_any;
  logic                 load_en;

  // A slot is open exactly when nothing is parked in it; no path from l2req_ready
  assign bus.req_ready = ~pending_q;
  assign capture       = bus.req_valid & ~pending_q;
  assign load_en       = !valid_q || bus.l2req_ready;

  l2_request_issue_rr_arbiter #(
    .NUM_UNITS (NUM_UNITS)
  ) u_arb (
    .req_i   (pending_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // Unpack a unit's fields into its slot when the handshake completes
  always_comb begin
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      slot_d[i] = slot_q[i];
      if (capture[i]) begin
        slot_d[i].strand  = bus.req_strand[L2_STRAND_W*i +: L2_STRAND_W];
        slot_d[i].op      = bus.req_op[L2_OP_W*i +: L2_OP_W];
        slot_d[i].way     = bus.req_way[L2_WAY_W*i +: L2_WAY_W];
        slot_d[i].address = bus.req_address[L2_ADDR_W*i +: L2_ADDR_W];
        slot_d[i].data    = bus.req_data[L2_LINE_BITS*i +: L2_LINE_BITS];
        slot_d[i].mask    = bus.req_mask[L2_LINE_BYTES*i +: L2_LINE_BYTES];
      end
    end
  end

  // Output register load, pending bookkeeping and pointer advance.
  // Capture and grant never hit the same slot: grant needs pending=1, capture pending=0.
  always_comb begin
    out_d     = out_q;
    valid_d   = valid_q;
    unit_d    = unit_q;
    rr_ptr_d  = rr_ptr_q;
    pending_d = pending_q | capture;
    if (load_en) begin
      if (grant_any) begin
        out_d     = slot_q[grant_idx];
        unit_d    = grant_idx;
        valid_d   = 1'b1;
        rr_ptr_d  = rr_next(grant_idx, NUM_UNITS);
        pending_d = pending_d & ~grant;
      end else begin
        valid_d   = 1'b0;
      end
    end
  end

  // Per-unit slot storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Pending flags, output register and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      unit_q    <= '0;
      rr_ptr_q  <= '0;
    end else begin
      pending_q <= pending_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      unit_q    <= unit_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus.l2req_valid   = valid_q;
  assign bus.l2req_unit    = unit_q;
  assign bus.l2req_strand  = out_q.strand;
  assign bus.l2req_op      = out_q.op;
  assign bus.l2req_way     = out_q.way;
  assign bus.l2req_address = out_q.address;
  assign bus.l2req_data    = out_q.data;
  assign bus.l2req_mask    = out_q.mask;

`ifdef L2REQ_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where the output waits on L2; wraps naturally
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !bus.l2req_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_l2req_stall_count = stall_cnt_q;
`endif

endmodule
